rx_frame_ctrl: RTL and testbench

RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

---
 rtl/rx_frame_if.sv | 48 ++++
 rtl/rx_frame_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/rx_frame_if.sv
// ---------------------------------------------------------------------------
// rx_frame_if
// Bundles the serial receive line, the start-bit strobe, the consumer
// acknowledge and the receiver status/data outputs of rx_frame_ctrl.
//   serial_in          : synchronized serial line, idle high
//   start_bit_detected : one-cycle pulse from the upstream start-bit detector
//   data_read          : consumer acknowledge for rx_data
//   rx_data            : last good received word (LSB first on the line)
//   data_ready         : rx_data holds an unread word
//   framing_error      : last frame had a stop bit of 0
//   overrun_error      : an unread word was overwritten
//   rx_busy            : receiver FSM is not idle
// master = line/consumer side, slave = the receiver.
// ---------------------------------------------------------------------------
interface rx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 serial_in;
    logic                 start_bit_detected;
    logic                 data_read;
    logic [DATA_BITS-1:0] rx_data;
    logic                 data_ready;
    logic                 framing_error;
    logic                 overrun_error;
    logic                 rx_busy;

    modport master (
        output serial_in,
        output start_bit_detected,
        output data_read,
        input  rx_data,
        input  data_ready,
        input  framing_error,
        input  overrun_error,
        input  rx_busy
    );

    modport slave (
        input  serial_in,
        input  start_bit_detected,
        input  data_read,
        output rx_data,
        output data_ready,
        output framing_error,
        output overrun_error,
        output rx_busy
    );
endinterface

// File: rtl/rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// rx_frame_ctrl
// Serial frame receiver: after an upstream start-bit pulse it verifies the
// start bit at mid-bit, samples DATA_BITS data bits (LSB first) once per bit
// period, checks the stop bit and loads the word into rx_data.
// Ports:
//   clk   : system clock, rising-edge active
//   n_rst : asynchronous active-low reset
//   bus   : rx_frame_if.slave (line, start strobe, acknowledge, status/data)
// Parameters:
//   BIT_PERIOD : clock cycles per serial bit (even, 4..1024)
//   DATA_BITS  : data bits per frame (5..8)
// ---------------------------------------------------------------------------
module rx_frame_ctrl #(
    parameter int BIT_PERIOD = 10,
    parameter int DATA_BITS  = 8
) (
    input  logic         clk,
    input  logic         n_rst,
    rx_frame_if.slave    bus
);

    localparam int CNT_W = $clog2(BIT_PERIOD);
    localparam int IDX_W = 3;

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    // Last count before the mid-bit sample of the start bit.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_PERIOD / 2 - 1);
    // Last count before a full-period sample (data and stop bits).
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_LOAD  = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [IDX_W-1:0]       idx_r;
    logic [DATA_BITS-1:0]   shreg_r;
    logic [DATA_BITS-1:0]   rx_data_r;
    logic                   data_ready_r;
    logic                   framing_error_r;
    logic                   overrun_error_r;
    logic                   rx_busy_r;

    logic                   cnt_clr_s;
    logic                   idx_clr_s;
    logic                   idx_inc_s;
    logic                   shift_en_s;
    logic                   load_s;
    logic                   ferr_set_s;
    logic                   ferr_clr_s;

    // State register; rx_busy is registered from the next state so it tracks the FSM exactly.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r   <= ST_IDLE;
            rx_busy_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            rx_busy_r <= (next_state_s != ST_IDLE);
        end
    end

    // Next-state logic and per-cycle datapath strobes.
    always_comb begin
        next_state_s = state_r;
        cnt_clr_s    = 1'b0;
        idx_clr_s    = 1'b0;
        idx_inc_s    = 1'b0;
        shift_en_s   = 1'b0;
        load_s       = 1'b0;
        ferr_set_s   = 1'b0;
        ferr_clr_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Counters are held at zero while idle.
                cnt_clr_s = 1'b1;
                if (bus.start_bit_detected) begin
                    next_state_s = ST_START;
                    idx_clr_s    = 1'b1;
                    ferr_clr_s   = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_clr_s = 1'b1;
                    // A high line at mid start bit is a glitch, not a frame.
                    if (bus.serial_in) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_DATA;
                    end
                end else begin
                    next_state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_r == FULL_LAST) begin
                    cnt_clr_s  = 1'b1;
                    shift_en_s = 1'b1;
                    if (idx_r == IDX_LAST) begin
                        idx_clr_s    = 1'b1;
                        next_state_s = ST_STOP;
                    end else begin
                        idx_inc_s    = 1'b1;
                        next_state_s = ST_DATA;
                    end
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (cnt_r == FULL_LAST) begin
                    cnt_clr_s = 1'b1;
                    if (bus.serial_in) begin
                        next_state_s = ST_LOAD;
                    end else begin
                        ferr_set_s   = 1'b1;
                        next_state_s = ST_IDLE;
                    end
                end else begin
                    next_state_s = ST_STOP;
                end
            end
            ST_LOAD: begin
                load_s       = 1'b1;
                cnt_clr_s    = 1'b1;
                next_state_s = ST_IDLE;
            end
            default: begin
                cnt_clr_s    = 1'b1;
                idx_clr_s    = 1'b1;
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Bit-period counter, bit-index counter and LSB-first shift register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_r   <= CNT_ZERO;
            idx_r   <= IDX_ZERO;
            shreg_r <= '0;
        end else begin
            if (cnt_clr_s) begin
                cnt_r <= CNT_ZERO;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            if (idx_clr_s) begin
                idx_r <= IDX_ZERO;
            end else if (idx_inc_s) begin
                idx_r <= idx_r + IDX_ONE;
            end else begin
                idx_r <= idx_r;
            end
            // Shifting right places the first received bit in the LSB.
            if (shift_en_s) begin
                shreg_r <= {bus.serial_in, shreg_r[DATA_BITS-1:1]};
            end else begin
                shreg_r <= shreg_r;
            end
        end
    end

    // Output word and status flags; a load takes priority over a consumer read.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data_r       <= '0;
            data_ready_r    <= 1'b0;
            overrun_error_r <= 1'b0;
            framing_error_r <= 1'b0;
        end else begin
            if (load_s) begin
                rx_data_r    <= shreg_r;
                data_ready_r <= 1'b1;
                if (data_ready_r && !bus.data_read) begin
                    overrun_error_r <= 1'b1;
                end else begin
                    overrun_error_r <= overrun_error_r;
                end
            end else if (bus.data_read) begin
                rx_data_r       <= rx_data_r;
                data_ready_r    <= 1'b0;
                overrun_error_r <= 1'b0;
            end else begin
                rx_data_r       <= rx_data_r;
                data_ready_r    <= data_ready_r;
                overrun_error_r <= overrun_error_r;
            end
            if (ferr_set_s) begin
                framing_error_r <= 1'b1;
            end else if (ferr_clr_s) begin
                framing_error_r <= 1'b0;
            end else begin
                framing_error_r <= framing_error_r;
            end
        end
    end

    assign bus.rx_data       = rx_data_r;
    assign bus.data_ready    = data_ready_r;
    assign bus.framing_error = framing_error_r;
    assign bus.overrun_error = overrun_error_r;
    assign bus.rx_busy       = rx_busy_r;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rx_frame_ctrl
// Directed bench for rx_frame_ctrl (BIT_PERIOD=10, DATA_BITS=8). A table of
// frame records is applied in sequence; each record gives the frame content,
// consumer-read timing and the expected status at edge 95 and after edge 96
// (edge 0 = the edge that samples start_bit_detected). Reset and mid-frame
// reset are exercised by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_rx_frame_ctrl;

    localparam int BP = 10;
    localparam int DB = 8;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       false_start;
        logic       read_before;
        logic       read_on_load;
        logic       exp_ready_95;
        logic       exp_ferr_95;
        logic [7:0] exp_data;
        logic       exp_ready;
        logic       exp_ferr;
        logic       exp_oerr;
    } vec_t;

    logic tb_clk;
    logic n_rst;
    int   tests_run;
    int   tests_failed;

    rx_frame_if #(.DATA_BITS(DB)) bus ();

    rx_frame_ctrl #(.BIT_PERIOD(BP), .DATA_BITS(DB)) dut (
        .clk   (tb_clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Line level to present before edge e: segment 0 is the start bit,
    // segments 1..8 the data bits LSB first, segment 9 the stop bit.
    function automatic logic line_bit(input logic [7:0] d, input logic stop,
                                      input logic fs, input int e);
        int seg;
        seg = (e - 1) / BP;
        if (fs && e >= 3) return 1'b1;
        if (seg == 0) return 1'b0;
        if (seg <= DB) return d[seg-1];
        return stop;
    endfunction

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    // Drives one frame for n_edges edges after the start pulse, checking
    // mid-frame observables named with tag.
    task automatic run_frame(input vec_t v, input int n_edges, input string tag);
        if (v.read_before) begin
            bus.data_read = 1'b1;
            tick();
            bus.data_read = 1'b0;
        end
        bus.start_bit_detected = 1'b1;
        bus.serial_in          = 1'b0;
        tick();                                   // edge 0
        bus.start_bit_detected = 1'b0;
        check({tag, " busy_e0"}, {31'd0, bus.rx_busy}, 32'd1);
        for (int e = 1; e <= n_edges; e++) begin
            bus.serial_in = line_bit(v.data, v.stop_bit, v.false_start, e);
            bus.data_read = (v.read_on_load && e == 96) ? 1'b1 : 1'b0;
            tick();
            bus.data_read = 1'b0;
            if (v.false_start && e == 4)
                check({tag, " busy_e4"}, {31'd0, bus.rx_busy}, 32'd1);
            if (v.false_start && e == 5)
                check({tag, " busy_e5"}, {31'd0, bus.rx_busy}, 32'd0);
            if (e == 95) begin
                check({tag, " ready_e95"}, {31'd0, bus.data_ready},    {31'd0, v.exp_ready_95});
                check({tag, " ferr_e95"},  {31'd0, bus.framing_error}, {31'd0, v.exp_ferr_95});
            end
        end
        bus.serial_in = 1'b1;
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, " data"},  {24'd0, bus.rx_data},       {24'd0, v.exp_data});
        check({tag, " ready"}, {31'd0, bus.data_ready},    {31'd0, v.exp_ready});
        check({tag, " ferr"},  {31'd0, bus.framing_error}, {31'd0, v.exp_ferr});
        check({tag, " oerr"},  {31'd0, bus.overrun_error}, {31'd0, v.exp_oerr});
        check({tag, " busy"},  {31'd0, bus.rx_busy},       32'd0);
    endtask

    initial begin
        vec_t vecs[10];
        vec_t v5a;
        tests_run    = 0;
        tests_failed = 0;

        //           data   stop  fs    rdb   rdl   rdy95 fer95 exp_d  rdy   fer   oer
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0}; // good frame
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0}; // false start
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0}; // framing error
        vecs[3] = '{8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0}; // clears ferr
        vecs[4] = '{8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b1}; // overrun
        vecs[5] = '{8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0}; // read clears
        vecs[6] = '{8'h44, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 1'b0}; // read on load
        vecs[7] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b1}; // overrun again
        vecs[8] = '{8'h66, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h66, 1'b1, 1'b0, 1'b1}; // oerr held
        vecs[9] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h66, 1'b0, 1'b1, 1'b0}; // ferr, no load
        v5a     = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0};

        n_rst                  = 1'b0;
        bus.serial_in          = 1'b1;
        bus.start_bit_detected = 1'b0;
        bus.data_read          = 1'b0;
        #3;
        check("rst data",  {24'd0, bus.rx_data},       32'd0);
        check("rst ready", {31'd0, bus.data_ready},    32'd0);
        check("rst ferr",  {31'd0, bus.framing_error}, 32'd0);
        check("rst oerr",  {31'd0, bus.overrun_error}, 32'd0);
        check("rst busy",  {31'd0, bus.rx_busy},       32'd0);
        tick();
        tick();
        n_rst = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 10; i++) begin
            run_frame(vecs[i], 96, $sformatf("vec%0d", i));
            check_outputs($sformatf("vec%0d", i), vecs[i]);
            tick();
            tick();
        end

        // Mid-frame reset: outputs are non-zero going in (rx_data=0x66, ferr=1).
        run_frame(v5a, 40, "midrst");
        check("midrst busy_pre", {31'd0, bus.rx_busy}, 32'd1);
        n_rst = 1'b0;
        #1;
        check("midrst data",  {24'd0, bus.rx_data},       32'd0);
        check("midrst ready", {31'd0, bus.data_ready},    32'd0);
        check("midrst ferr",  {31'd0, bus.framing_error}, 32'd0);
        check("midrst oerr",  {31'd0, bus.overrun_error}, 32'd0);
        check("midrst busy",  {31'd0, bus.rx_busy},       32'd0);
        tick();
        tick();
        n_rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.serial_in = i[0];
            tick();
        end
        bus.serial_in = 1'b1;
        check("midrst idle_wait busy", {31'd0, bus.rx_busy}, 32'd0);
        check("midrst idle_wait ready", {31'd0, bus.data_ready}, 32'd0);
        tick();
        run_frame(v5a, 96, "after_rst");
        check_outputs("after_rst", v5a);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
